proc_io_csr: RTL

PROC_IO_CSR -- requirements
Module: proc_io_csr

---
 rtl/proc_io_csr.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/proc_io_csr.sv
// proc_io_csr: processor CSR bridge to NCH input/output channel pairs.
//
// Input side: each channel has a one-entry holding register plus a full flag.
// An external producer fills it through in_val/in_rdy, and the processor drains
// it with a CSR read (rd_val/rd_chan). rd_stall is raised while the selected
// register is still empty.
//
// Output side: each channel has a DEPTH-entry FIFO. The processor fills it with
// CSR writes (wr_val/wr_chan/wr_data). An external consumer drains it through
// out_val/out_rdy. wr_stall is raised while the selected FIFO is full.
//
// Ports:
//   clk, rst (async, active-low)
//   rd_val, rd_chan, rd_data, rd_stall   CSR read of an input channel
//   wr_val, wr_chan, wr_data, wr_stall   CSR write to an output channel
//   in_val, in_data, in_rdy              producer side, channel i at [i*W +: W]
//   out_val, out_data, out_rdy           consumer side, same packing
module proc_io_csr #(
  parameter int NCH   = 3,
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_val,
  input  logic [CW-1:0]      rd_chan,
  output logic [W-1:0]       rd_data,
  output logic               rd_stall,
  input  logic               wr_val,
  input  logic [CW-1:0]      wr_chan,
  input  logic [W-1:0]       wr_data,
  output logic               wr_stall,
  input  logic [NCH-1:0]     in_val,
  input  logic [NCH*W-1:0]   in_data,
  output logic [NCH-1:0]     in_rdy,
  output logic [NCH-1:0]     out_val,
  output logic [NCH*W-1:0]   out_data,
  input  logic [NCH-1:0]     out_rdy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [NCH-1:0]  full_r;
  logic [W-1:0]    hold_r [NCH];
  logic [W-1:0]    mem_r  [NCH][DEPTH];
  logic [AW-1:0]   wp_r   [NCH];
  logic [AW-1:0]   rp_r   [NCH];
  logic [CNTW-1:0] cnt_r  [NCH];

  logic [NCH-1:0]  rd_sel_s;
  logic [NCH-1:0]  wr_sel_s;
  logic [NCH-1:0]  cap_s;
  logic [NCH-1:0]  rd_fire_s;
  logic [NCH-1:0]  wr_fire_s;
  logic [NCH-1:0]  pop_s;
  logic [NCH-1:0]  fifo_full_s;
  logic [NCH-1:0]  fifo_nempty_s;
  logic [W-1:0]    rd_data_s;

  // Per-channel decode of selects, handshakes and fire conditions.
  // An out-of-range channel index matches no channel, so it can neither
  // stall nor change state.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_sel_s[i]      = (rd_chan == CW'(i));
      wr_sel_s[i]      = (wr_chan == CW'(i));
      fifo_full_s[i]   = (cnt_r[i] == CNTW'(DEPTH));
      fifo_nempty_s[i] = (cnt_r[i] != '0);
      cap_s[i]         = in_val[i] & ~full_r[i];
      rd_fire_s[i]     = rd_val & rd_sel_s[i] & full_r[i];
      wr_fire_s[i]     = wr_val & wr_sel_s[i] & ~fifo_full_s[i];
      pop_s[i]         = fifo_nempty_s[i] & out_rdy[i];
      rd_data_s        = rd_data_s | ((rd_sel_s[i] & full_r[i]) ? hold_r[i] : '0);
    end
  end

  // FIFO head presentation; an empty FIFO drives zeros.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NCH; i++) begin
      out_data[i*W +: W] = fifo_nempty_s[i] ? mem_r[i][rp_r[i]] : '0;
    end
  end

  // The rst gating forces the handshake outputs low during reset, even though
  // the full flags are already cleared by then.
  assign in_rdy   = {NCH{rst}} & ~full_r;
  assign rd_stall = rst & rd_val & (|(rd_sel_s & ~full_r));
  assign rd_data  = rst ? rd_data_s : '0;
  assign wr_stall = rst & wr_val & (|(wr_sel_s & fifo_full_s));
  assign out_val  = fifo_nempty_s;

  // Control state: full flags, FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        wp_r[i]  <= '0;
        rp_r[i]  <= '0;
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // A capture needs the flag clear and a read fire needs it set,
        // so these two events never coincide.
        if (cap_s[i]) begin
          full_r[i] <= 1'b1;
        end else if (rd_fire_s[i]) begin
          full_r[i] <= 1'b0;
        end else begin
          full_r[i] <= full_r[i];
        end
        // DEPTH is a power of two, so natural overflow wraps the pointers.
        if (wr_fire_s[i]) begin
          wp_r[i] <= wp_r[i] + AW'(1);
        end
        if (pop_s[i]) begin
          rp_r[i] <= rp_r[i] + AW'(1);
        end
        case ({wr_fire_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNTW'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CNTW'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Data storage. It needs no reset because the flags and counts
  // qualify every read of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (cap_s[i]) begin
        hold_r[i] <= in_data[i*W +: W];
      end
      if (wr_fire_s[i]) begin
        mem_r[i][wp_r[i]] <= wr_data;
      end
    end
  end

endmodule
